// File: rtl/bp_me_wb_pkg.sv
// Shared types for the BedRock-to-Wishbone master bridge: BedRock header layout,
// bridge FSM states and the size/offset to byte-select helpers.
package bp_me_wb_pkg;

    localparam int paddr_width_gp   = 40;
    localparam int payload_width_gp = 16;
    localparam int dword_width_gp   = 64;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'b0000,
        e_bedrock_mem_wr    = 4'b0001,
        e_bedrock_mem_uc_rd = 4'b0010,
        e_bedrock_mem_uc_wr = 4'b0011,
        e_bedrock_mem_pre   = 4'b0100,
        e_bedrock_mem_amo   = 4'b0101
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'b000,
        e_bedrock_msg_size_2   = 3'b001,
        e_bedrock_msg_size_4   = 3'b010,
        e_bedrock_msg_size_8   = 3'b011,
        e_bedrock_msg_size_16  = 3'b100,
        e_bedrock_msg_size_32  = 3'b101,
        e_bedrock_msg_size_64  = 3'b110,
        e_bedrock_msg_size_128 = 3'b111
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [payload_width_gp-1:0] payload;
        bp_bedrock_msg_size_e        size;
        logic [paddr_width_gp-1:0]   addr;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_mem_header_s;

    typedef enum logic [1:0] {
        e_ready  = 2'd0,
        e_wb_req = 2'd1,
        e_rev    = 2'd2
    } bp_me_wb_state_e;

    // Byte lanes touched by an access of 2^size bytes at the given lane offset.
    function automatic logic [7:0] size_to_sel(input bp_bedrock_msg_size_e size,
                                               input logic [2:0] offset);
        logic [3:0] nbytes;
        logic [7:0] mask;
        if (size >= e_bedrock_msg_size_8) return 8'hFF;
        nbytes = 4'(1) << size;
        mask   = (8'(1) << nbytes) - 8'd1;
        return mask << offset;
    endfunction

    function automatic logic [2:0] size_to_mask(input bp_bedrock_msg_size_e size);
        if (size >= e_bedrock_msg_size_8) return 3'b111;
        return 3'((4'(1) << size) - 4'd1);
    endfunction

    function automatic logic is_write(input bp_bedrock_mem_type_e msg_type);
        return (msg_type == e_bedrock_mem_wr) || (msg_type == e_bedrock_mem_uc_wr);
    endfunction

endpackage

// File: rtl/bp_me_wb_if.sv
// Wishbone B4 classic bus between the bridge (master) and a peripheral (slave).
// Signal names keep the master's point of view.
interface bp_me_wb_if #(
    parameter int data_width_p = 64,
    parameter int adr_width_p  = 37
);
    logic [adr_width_p-1:0]    adr_o;
    logic [data_width_p-1:0]   dat_o;
    logic [data_width_p-1:0]   dat_i;
    logic [data_width_p/8-1:0] sel_o;
    logic                      cyc_o;
    logic                      stb_o;
    logic                      we_o;
    logic                      ack_i;

    modport master (output adr_o, dat_o, sel_o, cyc_o, stb_o, we_o,
                    input  dat_i, ack_i);
    modport slave  (input  adr_o, dat_o, sel_o, cyc_o, stb_o, we_o,
                    output dat_i, ack_i);
endinterface

// File: rtl/bp_me_wb_sel_gen.sv
// Combinational Wishbone byte-select generation from a BedRock size and lane offset.
module bp_me_wb_sel_gen
    import bp_me_wb_pkg::*;
#(
    parameter int sel_width_p = 8
) (
    input  bp_bedrock_msg_size_e   size,
    input  logic [2:0]             offset,
    output logic [sel_width_p-1:0] sel
);
    logic [7:0] sel_full;

    always_comb sel_full = size_to_sel(size, offset);

    assign sel = sel_full[sel_width_p-1:0];
endmodule

// File: rtl/bp_me_wb_master.sv
// Bridges single-beat BedRock memory forwards onto a Wishbone B4 classic bus and
// returns each completion as a BedRock reverse message; one transaction at a time.
module bp_me_wb_master
    import bp_me_wb_pkg::*;
#(
    parameter int data_width_p = dword_width_gp
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  bp_bedrock_mem_header_s  mem_fwd_header_i,
    input  logic [data_width_p-1:0] mem_fwd_data_i,
    input  logic                    mem_fwd_v_i,
    output logic                    mem_fwd_ready_and_o,
    input  logic                    mem_fwd_last_i,
    output bp_bedrock_mem_header_s  mem_rev_header_o,
    output logic [data_width_p-1:0] mem_rev_data_o,
    output logic                    mem_rev_v_o,
    input  logic                    mem_rev_ready_and_i,
    output logic                    mem_rev_last_o,
    bp_me_wb_if.master              wb,
    output bp_me_wb_state_e         state_o
);
    localparam int         sel_w_lp        = data_width_p / 8;
    localparam int         wb_adr_width_lp = paddr_width_gp - $clog2(sel_w_lp);
    localparam logic [2:0] off_mask_lp     = 3'(sel_w_lp - 1);

    if (!(data_width_p == 8 || data_width_p == 16 || data_width_p == 32 || data_width_p == 64))
    begin : g_bad_width
        $error("bp_me_wb_master: data_width_p must be 8, 16, 32 or 64");
    end
    if (data_width_p != dword_width_gp) begin : g_narrow_width
        $warning("bp_me_wb_master: data_width_p is narrower than a dword");
    end

    bp_me_wb_state_e        state_r, state_n;
    bp_bedrock_mem_header_s hdr_r;
    logic [data_width_p-1:0] fwd_data_r, rev_data_r;
    logic [sel_w_lp-1:0]     sel_r, sel_n;
    logic                    we_r;
    logic                    fwd_ready, wb_active, rev_valid;
    logic [2:0]              rd_off, rd_mask;
    logic [data_width_p-1:0] rd_shift, rd_pack;

    bp_me_wb_sel_gen #(.sel_width_p(sel_w_lp)) u_sel_gen (
        .size   (mem_fwd_header_i.size),
        .offset (mem_fwd_header_i.addr[2:0] & off_mask_lp),
        .sel    (sel_n)
    );

    // valid/ready: a transfer happens on a rising clk_i where valid and ready are
    // both 1; the sender holds valid and keeps the payload stable until then.
    always_comb begin
        state_n   = state_r;
        fwd_ready = 1'b0;
        wb_active = 1'b0;
        rev_valid = 1'b0;
        case (state_r)
            e_ready: begin
                fwd_ready = 1'b1;
                if (mem_fwd_v_i) state_n = e_wb_req;
            end
            e_wb_req: begin
                wb_active = 1'b1;
                if (wb.ack_i) state_n = e_rev;
            end
            e_rev: begin
                rev_valid = 1'b1;
                if (mem_rev_ready_and_i) state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    // Read data arrives lane-aligned; move the addressed bytes to lane 0 and
    // replicate them across the bus, as the BP side expects for sub-word sizes.
    always_comb begin
        rd_off   = hdr_r.addr[2:0] & off_mask_lp;
        rd_mask  = size_to_mask(hdr_r.size) & off_mask_lp;
        rd_shift = wb.dat_i >> {rd_off, 3'b000};
        rd_pack  = '0;
        for (int i = 0; i < sel_w_lp; i++) begin
            rd_pack[8*i +: 8] = rd_shift[8*(i & int'(rd_mask)) +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_ready;
            hdr_r      <= '0;
            fwd_data_r <= '0;
            sel_r      <= '0;
            we_r       <= 1'b0;
            rev_data_r <= '0;
        end else begin
            state_r <= state_n;
            if (fwd_ready && mem_fwd_v_i) begin
                hdr_r      <= mem_fwd_header_i;
                fwd_data_r <= mem_fwd_data_i;
                sel_r      <= sel_n;
                we_r       <= is_write(mem_fwd_header_i.msg_type);
            end
            if (wb_active && wb.ack_i) begin
                rev_data_r <= we_r ? '0 : rd_pack;
            end
        end
    end

    assign mem_fwd_ready_and_o = fwd_ready;
    assign wb.cyc_o            = wb_active;
    assign wb.stb_o            = wb_active;
    assign wb.we_o             = we_r;
    assign wb.sel_o            = sel_r;
    assign wb.dat_o            = fwd_data_r;
    assign wb.adr_o            = hdr_r.addr[paddr_width_gp-1 -: wb_adr_width_lp];
    assign mem_rev_v_o         = rev_valid;
    assign mem_rev_header_o    = hdr_r;
    assign mem_rev_data_o      = rev_data_r;
    assign mem_rev_last_o      = 1'b1;
    assign state_o             = state_r;

    // Protocol checks on every accepted forward message.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && fwd_ready && mem_fwd_v_i) begin
            assert (mem_fwd_last_i)
                else $error("bp_me_wb_master: multi-beat forward message");
            assert ((1 << int'(mem_fwd_header_i.size)) <= sel_w_lp)
                else $error("bp_me_wb_master: access size wider than the bus");
            assert ((mem_fwd_header_i.addr[2:0] & off_mask_lp
                     & size_to_mask(mem_fwd_header_i.size)) == 3'b000)
                else $error("bp_me_wb_master: misaligned access");
        end
    end

endmodule

// File: tb/tb_bp_me_wb_master.sv
// Directed and randomized checks of bp_me_wb_master against a byte-level memory
// model and a Wishbone slave with programmable wait states.
module tb_bp_me_wb_master;
    import bp_me_wb_pkg::*;

    localparam int dw_lp = 64;
    localparam int aw_lp = paddr_width_gp - 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_n;
    bp_bedrock_mem_header_s fwd_hdr, rev_hdr, last_hdr;
    logic [dw_lp-1:0]       fwd_data, rev_data;
    logic                   fwd_v, fwd_ready, fwd_last, rev_v, rev_ready, rev_last;
    bp_me_wb_state_e        state;

    bp_me_wb_if #(.data_width_p(dw_lp), .adr_width_p(aw_lp)) wb ();

    bp_me_wb_master #(.data_width_p(dw_lp)) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .mem_fwd_header_i    (fwd_hdr),
        .mem_fwd_data_i      (fwd_data),
        .mem_fwd_v_i         (fwd_v),
        .mem_fwd_ready_and_o (fwd_ready),
        .mem_fwd_last_i      (fwd_last),
        .mem_rev_header_o    (rev_hdr),
        .mem_rev_data_o      (rev_data),
        .mem_rev_v_o         (rev_v),
        .mem_rev_ready_and_i (rev_ready),
        .mem_rev_last_o      (rev_last),
        .wb                  (wb),
        .state_o             (state)
    );

    int errors = 0;
    int checks = 0;
    int fwd_count = 0, rev_count = 0, txn_sent = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wishbone slave: word memory, wait states, optional forced read data.
    logic [63:0]      wb_mem [logic [36:0]];
    int               slv_wait = 0;
    logic             slv_force = 1'b0;
    logic [63:0]      slv_force_data = '0;
    logic             spur_req = 1'b0;
    int               stb_cycles = 0;
    logic             stable_ok = 1'b1;
    logic [aw_lp-1:0] snap_adr;
    logic [7:0]       snap_sel;
    logic             snap_we;
    logic [63:0]      snap_dat;

    initial begin
        int   cnt;
        logic in_cyc;
        logic [63:0] tmp;
        cnt = 0;
        in_cyc = 1'b0;
        wb.ack_i = 1'b0;
        wb.dat_i = '0;
        forever begin
            @(negedge clk);
            wb.ack_i = 1'b0;
            if (wb.cyc_o && wb.stb_o) begin
                if (!in_cyc) begin
                    in_cyc = 1'b1; stb_cycles = 0; stable_ok = 1'b1;
                    snap_adr = wb.adr_o; snap_sel = wb.sel_o;
                    snap_we = wb.we_o; snap_dat = wb.dat_o;
                end else if (wb.adr_o !== snap_adr || wb.sel_o !== snap_sel ||
                             wb.we_o !== snap_we || wb.dat_o !== snap_dat) begin
                    stable_ok = 1'b0;
                end
                stb_cycles++;
                if (cnt >= slv_wait) begin
                    wb.ack_i = 1'b1; cnt = 0; in_cyc = 1'b0;
                    if (wb.we_o) begin
                        tmp = wb_mem.exists(wb.adr_o) ? wb_mem[wb.adr_o] : 64'h0;
                        for (int b = 0; b < 8; b++)
                            if (wb.sel_o[b]) tmp[8*b +: 8] = wb.dat_o[8*b +: 8];
                        wb_mem[wb.adr_o] = tmp;
                    end else begin
                        wb.dat_i = slv_force ? slv_force_data
                                 : (wb_mem.exists(wb.adr_o) ? wb_mem[wb.adr_o] : 64'h0);
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0; in_cyc = 1'b0;
                if (spur_req) begin
                    wb.ack_i = 1'b1; wb.dat_i = 64'hDEAD_BEEF_0BAD_F00D; spur_req = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (fwd_v && fwd_ready) fwd_count++;
        if (rev_v && rev_ready) rev_count++;
    end

    // Reference model: byte-addressed memory; a read returns the 2^size bytes at
    // addr replicated across 8 lanes, a write stores the low 2^size data bytes.
    logic [7:0] ref_mem [logic [39:0]];

    function automatic bit tb_is_wr(input bp_bedrock_mem_type_e t);
        return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
    endfunction

    function automatic logic [63:0] model_access(input bp_bedrock_mem_type_e t, input int size,
                                                 input logic [39:0] addr, input logic [63:0] data);
        int n;
        logic [63:0] r;
        logic [39:0] a;
        n = 1 << size;
        r = '0;
        if (tb_is_wr(t)) begin
            for (int k = 0; k < n; k++) ref_mem[addr + 40'(k)] = data[8*k +: 8];
            return 64'h0;
        end
        for (int i = 0; i < 8; i++) begin
            a = addr + 40'(i % n);
            r[8*i +: 8] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
        end
        return r;
    endfunction

    task automatic do_txn(input bp_bedrock_mem_type_e t, input int size, input logic [39:0] addr,
                          input logic [63:0] data, input int waits, input int bp, input bit poke,
                          input logic [63:0] exp_rdata);
        bp_bedrock_mem_header_s hdr, junk;
        int   bound, lat, n;
        logic [7:0] exp_sel;
        hdr.msg_type = t;
        hdr.addr     = addr;
        hdr.size     = bp_bedrock_msg_size_e'(size);
        hdr.payload  = 16'($urandom);
        junk         = hdr;
        junk.addr    = ~hdr.addr;
        n            = 1 << size;
        exp_sel      = 8'(((1 << n) - 1) << addr[2:0]);
        slv_wait     = waits;
        @(negedge clk);
        fwd_hdr = hdr; fwd_data = data; fwd_v = 1'b1;
        bound = 0;
        while (!fwd_ready && bound < 50) begin @(negedge clk); bound++; end
        if (!fwd_ready) begin check("fwd_accept_timeout", 64'd0, 64'd1); fwd_v = 1'b0; return; end
        @(posedge clk);
        txn_sent++;
        @(negedge clk);
        fwd_v = 1'b0;
        check("stb_after_fwd", 64'(wb.stb_o), 64'd1);
        check("fwd_ready_busy", 64'(fwd_ready), 64'd0);
        lat = 1;
        while (!rev_v && lat < 200) begin @(negedge clk); lat++; end
        check("rev_latency", 64'(lat), 64'(waits + 2));
        if (!rev_v) return;
        check("wb_adr", 64'(snap_adr), 64'(addr[39:3]));
        check("wb_sel", 64'(snap_sel), 64'(exp_sel));
        check("wb_we", 64'(snap_we), 64'(tb_is_wr(t)));
        if (tb_is_wr(t)) check("wb_dat", snap_dat, data);
        check("wb_stb_cycles", 64'(stb_cycles), 64'(waits + 1));
        check("wb_stable", 64'(stable_ok), 64'd1);
        for (int i = 0; i < bp; i++) begin
            if (poke) begin fwd_hdr = junk; fwd_v = 1'b1; end
            check("rev_hold_v", 64'(rev_v), 64'd1);
            check("rev_hold_data", rev_data, exp_rdata);
            if (poke) check("fwd_blocked", 64'(fwd_ready), 64'd0);
            @(negedge clk);
        end
        rev_ready = 1'b1;
        fwd_v = 1'b0;
        check("rev_hdr", 64'(rev_hdr), 64'(hdr));
        check("rev_data", rev_data, exp_rdata);
        check("rev_last", 64'(rev_last), 64'd1);
        last_hdr = rev_hdr;
        @(posedge clk);
        @(negedge clk);
        rev_ready = 1'b0;
        check("rev_v_after", 64'(rev_v), 64'd0);
        check("fwd_ready_after", 64'(fwd_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bp_me_wb_state_e      t_pick [4];
        bp_bedrock_mem_type_e t;
        logic [63:0] v, d, wd, exp;
        logic [39:0] addr;
        int size, n, off, word;
        logic seen;

        t_pick = '{e_ready, e_ready, e_ready, e_ready};
        reset_n = 1'b1; fwd_hdr = '0; fwd_data = '0; fwd_v = 1'b0;
        fwd_last = 1'b1; rev_ready = 1'b0; last_hdr = '0;
        for (int w = 0; w < 64; w++) begin
            v = {$urandom, $urandom};
            wb_mem[37'h1000 + 37'(w)] = v;
            for (int b = 0; b < 8; b++) ref_mem[40'h8000 + 40'(w*8 + b)] = v[8*b +: 8];
        end
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 64'(wb.cyc_o), 64'd0);
        check("rst_stb", 64'(wb.stb_o), 64'd0);
        check("rst_we", 64'(wb.we_o), 64'd0);
        check("rst_sel", 64'(wb.sel_o), 64'd0);
        check("rst_adr", 64'(wb.adr_o), 64'd0);
        check("rst_dat", wb.dat_o, 64'd0);
        check("rst_rev_v", 64'(rev_v), 64'd0);
        check("rst_rev_hdr", 64'(rev_hdr), 64'd0);
        check("rst_rev_data", rev_data, 64'd0);
        check("rst_state", 64'(state), 64'(e_ready));
        #2 reset_n = 1'b1;

        // Stray acknowledge while idle must not start a response.
        @(negedge clk); spur_req = 1'b1;
        @(negedge clk); @(negedge clk);
        check("spur_state", 64'(state), 64'(e_ready));
        check("spur_rev_v", 64'(rev_v), 64'd0);
        check("spur_fwd_ready", 64'(fwd_ready), 64'd1);

        // Dword read, zero-wait slave.
        slv_force = 1'b1; slv_force_data = 64'h1122_3344_5566_7788;
        do_txn(e_bedrock_mem_uc_rd, 3, 40'h1000, 64'h0, 0, 0, 1'b0, 64'h1122_3344_5566_7788);
        check("d1_adr", 64'(snap_adr), 64'h200);
        check("d1_sel", 64'(snap_sel), 64'hFF);
        slv_force = 1'b0;

        // Byte write at lane 3.
        exp = model_access(e_bedrock_mem_uc_wr, 0, 40'h1003, {8{8'hAB}});
        do_txn(e_bedrock_mem_uc_wr, 0, 40'h1003, {8{8'hAB}}, 0, 0, 1'b0, exp);
        check("d2_sel", 64'(snap_sel), 64'h08);
        check("d2_dat", snap_dat, {8{8'hAB}});
        check("d2_msg_type", 64'(last_hdr.msg_type), 64'(e_bedrock_mem_uc_wr));

        // Halfword read at lane 6 with five wait states.
        slv_force = 1'b1; slv_force_data = 64'hBEEF_0000_0000_0000;
        do_txn(e_bedrock_mem_uc_rd, 1, 40'h2006, 64'h0, 5, 0, 1'b0, 64'hBEEF_BEEF_BEEF_BEEF);
        check("d3_stb_cycles", 64'(stb_cycles), 64'd6);
        slv_force = 1'b0;

        // Reverse backpressure with a competing forward, then a normal follow-up.
        exp = model_access(e_bedrock_mem_rd, 2, 40'h8014, 64'h0);
        do_txn(e_bedrock_mem_rd, 2, 40'h8014, 64'h0, 1, 10, 1'b1, exp);
        exp = model_access(e_bedrock_mem_rd, 3, 40'h8020, 64'h0);
        do_txn(e_bedrock_mem_rd, 3, 40'h8020, 64'h0, 0, 0, 1'b0, exp);

        // Asynchronous reset in the middle of a bus request.
        slv_wait = 100;
        @(negedge clk);
        fwd_hdr.msg_type = e_bedrock_mem_uc_rd; fwd_hdr.addr = 40'h8008;
        fwd_hdr.size = e_bedrock_msg_size_8; fwd_hdr.payload = 16'h5a5a; fwd_v = 1'b1;
        @(posedge clk);
        @(negedge clk); fwd_v = 1'b0;
        check("ar_cyc_before", 64'(wb.cyc_o), 64'd1);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("ar_cyc", 64'(wb.cyc_o), 64'd0);
        check("ar_stb", 64'(wb.stb_o), 64'd0);
        check("ar_sel", 64'(wb.sel_o), 64'd0);
        check("ar_state", 64'(state), 64'(e_ready));
        @(negedge clk);
        #3 reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (rev_v) seen = 1'b1; end
        check("ar_no_response", 64'(seen), 64'd0);
        exp = model_access(e_bedrock_mem_uc_rd, 3, 40'h8008, 64'h0);
        do_txn(e_bedrock_mem_uc_rd, 3, 40'h8008, 64'h0, 2, 1, 1'b0, exp);

        // Randomized mix against the byte-level model.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       t = e_bedrock_mem_rd;
                1:       t = e_bedrock_mem_wr;
                2:       t = e_bedrock_mem_uc_rd;
                default: t = e_bedrock_mem_uc_wr;
            endcase
            size = $urandom_range(0, 3);
            n    = 1 << size;
            off  = $urandom_range(0, 8 / n - 1) * n;
            word = $urandom_range(0, 63);
            addr = 40'h8000 + 40'(word * 8 + off);
            d    = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) wd[8*b +: 8] = d[8*(b % n) +: 8];
            if (!tb_is_wr(t)) wd = {$urandom, $urandom};
            exp = model_access(t, size, addr, wd);
            do_txn(t, size, addr, wd, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), exp);
        end

        repeat (2) @(negedge clk);
        check("rev_count", 64'(rev_count), 64'(txn_sent));
        check("fwd_count", 64'(fwd_count), 64'(txn_sent + 1));
        if (t_pick[0] != e_ready) $display("unexpected pick table");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_me_wb_master.md
Name: bp_me_wb_master

Overview:
- Bridges BedRock memory forwards from a BP initiator onto a Wishbone B4 classic (non-pipelined) bus as WB master.
- Returns each WB completion as a BedRock memory reverse message.
- Sits between a BP uncached I/O port and WB peripheral slaves; the complement of the existing WB-to-BedRock client adapter.
- Single outstanding transaction, single-beat messages only.

Parameters:
- bp_params_p, e_bp_default_cfg, BP configuration; supplies paddr_width_p, did_width_p, lce_id_width_p, lce_assoc_p.
- data_width_p, dword_width_gp (64), WB and BedRock data width; legal values 8/16/32/64.
- Derived: wb_adr_width_lp = paddr_width_p - log2(data_width_p/8); wb_sel_width_lp = data_width_p/8.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- mem_fwd_header_i  in  mem_fwd_header_width_lp  BedRock forward header
- mem_fwd_data_i  in  data_width_p  forward data; replicated for sub-word sizes
- mem_fwd_v_i  in  1  forward valid
- mem_fwd_ready_and_o  out  1  forward ready
- mem_fwd_last_i  in  1  forward last beat; always 1
- mem_rev_header_o  out  mem_rev_header_width_lp  reverse header
- mem_rev_data_o  out  data_width_p  reverse data
- mem_rev_v_o  out  1  reverse valid
- mem_rev_ready_and_i  in  1  reverse ready
- mem_rev_last_o  out  1  tied 1
- adr_o  out  wb_adr_width_lp  WB word address
- dat_o  out  data_width_p  WB write data
- cyc_o, stb_o  out  1  WB cycle and strobe
- sel_o  out  wb_sel_width_lp  WB byte select
- we_o  out  1  WB write enable
- dat_i  in  data_width_p  WB read data
- ack_i  in  1  WB acknowledge

Behaviour:
- Reset: clk_i/reset_n_i are the block's only clock and reset. Reset is asynchronous, active-low.
  - Asserting reset_n_i=0 at any time, including mid-transaction, forces state e_ready.
  - Every registered output goes to 0: cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, mem_rev_v_o, mem_rev_header_o, mem_rev_data_o.
  - A transaction in flight is dropped without any response.
- FSM states: e_ready, e_wb_req, e_rev.
- e_ready:
  - mem_fwd_ready_and_o=1; cyc_o=stb_o=0.
  - On mem_fwd_v_i: register header and data, then go to e_wb_req.
- e_wb_req:
  - cyc_o=stb_o=1; ready_and_o=0.
  - adr_o = header.addr[paddr_width_p-1:log2(sel_w)].
  - we_o=1 for e_bedrock_mem_uc_wr and e_bedrock_mem_wr; otherwise 0.
  - dat_o = registered forward data (already replicated by BP).
  - sel_o: ((1<<2^size)-1) << addr[log2(sel_w)-1:0]; size_8 gives all-ones.
  - All WB outputs hold stable until ack_i.
  - On ack_i: register read data, drop cyc_o/stb_o in the next cycle, go to e_rev.
- e_rev:
  - mem_rev_v_o=1.
  - mem_rev_header_o = registered forward header unchanged (msg_type, addr, size, payload).
  - Read: mem_rev_data_o = dat_i shifted right by the byte offset, then replicated to full width per size via bsg_bus_pack.
  - Write: mem_rev_data_o = 0.
  - On mem_rev_ready_and_i: go to e_ready.
- Latency:
  - Forward handshake to stb_o: 1 cycle.
  - ack_i to mem_rev_v_o: 1 cycle.
  - Minimum occupancy with a zero-wait slave: 3 cycles per transaction; no back-to-back overlap.
- Boundary conditions:
  - ack_i outside e_wb_req is ignored.
  - mem_fwd_v_i while busy: ready_and_o stays 0; the header is not sampled.
  - mem_rev_ready_and_i low holds e_rev indefinitely; the header and data stay stable.
  - Misaligned address/size (offset not a multiple of size): undefined; flagged by an assertion.
- Assertions:
  - mem_fwd_last_i=1 when handshaken.
  - size ≤ data_width_p/8.
  - data_width_p ∈ {8,16,32,64}.
  - A display message warns when data_width_p≠64.

Decomposition:
- Shared package bp_me_wb_pkg:
  - FSM enum type.
  - Function size_to_sel(size, offset).
- bsg_wb_pkg supplies width macros.
- One natural sub-module: bp_me_wb_sel_gen (combinational size/offset → sel_o), reused by the client adapter's checker.
- Reverse replication uses the existing bsg_bus_pack instance.

Test Plan:
- Read, size_8, addr 0x1000, slave returns 0x1122334455667788 after 0 waits → adr_o=0x200, sel_o=0xFF, we_o=0; mem_rev data 0x1122334455667788, header equal to forward header.
- Write, size_1, addr 0x1003, fwd data 0xABAB…AB → sel_o=0x08, we_o=1, dat_o=0xABAB…AB; mem_rev data 0, msg_type e_bedrock_mem_uc_wr.
- Read, size_2, addr 0x2006, slave dat_i=0xBEEF000000000000 with 5 wait cycles → WB outputs stable for 6 cycles; mem_rev data 0xBEEFBEEFBEEFBEEF.
- Backpressure: mem_rev_ready_and_i=0 for 10 cycles → mem_rev_v_o and data held; second forward not accepted (ready_and_o=0) until the reverse handshake.
- Async reset: reset_n_i low mid-e_wb_req, not aligned to a clock edge → cyc_o/stb_o fall immediately; after release the next read completes normally.
- Random mix of 1000 reads/writes against a WB memory model → every forward gets exactly one reverse message, in order, with matching data.
